reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file, the next generation of the 32×32 single-write register file in the CPU datapath. Two read ports and two write ports for dual-issue writeback, configurable width/depth, hardwired zero register, optional write-to-read bypass. Contents are initialised by a sequential sweep after reset or on a clear request, with a `ready_o` flag, instead of a single-cycle parallel load.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth `DEPTH = 2**ADDR_W`.
- `ZERO_REG`, 1: 1 means register 0 always reads 0 and ignores writes.
- `BYPASS`, 1: 1 means a read of an address written this cycle returns the write data.
- `SP_IDX`, 29: index of the stack-pointer register.
- `SP_INIT`, 128: value loaded into `SP_IDX` during init; all other registers init to 0.

Ports:
- `clk_i`  in  1  sole clock, rising edge.
- `rst_i`  in  1  synchronous, active-low reset.
- `clr_i`  in  1  request to re-run the init sweep.
- `ready_o`  out  1  high when in RUN; reset value 0.
- `RSaddr_i`, `RTaddr_i`  in  ADDR_W  read addresses.
- `RSdata_o`, `RTdata_o`  out  DATA_W  read data (combinational); 0 while `ready_o`=0.
- `WAaddr_i`, `WBaddr_i`  in  ADDR_W  write addresses, ports A and B.
- `WAdata_i`, `WBdata_i`  in  DATA_W  write data.
- `WAen_i`, `WBen_i`  in  1  write enables.

## Operation
- FSM states: INIT and RUN. A counter `cnt` has ADDR_W+1 bits.
- Reset (`rst_i`=0 at a rising edge) sets state to INIT, `cnt` to 0 and `ready_o` to 0. The array is not written on the reset edge itself.
- INIT, each edge with `rst_i`=1:
  - write the init value into `reg[cnt]`: `SP_INIT` if `cnt==SP_IDX`, else 0;
  - increment `cnt`;
  - after writing `DEPTH-1`, go to RUN and set `ready_o` to 1.
- INIT blocks user writes: `WAen_i` and `WBen_i` are ignored. Reads return 0.
- RUN writes:
  - each enabled port writes its data at the edge;
  - if both ports are enabled to the same address, port B wins;
  - with `ZERO_REG`=1, writes to address 0 are dropped.
- RUN reads are combinational from the array.
  - With `BYPASS`=1, a read address matching an enabled write address returns that write data. Port B has priority; bypass never applies to address 0 when `ZERO_REG`=1.
  - With `BYPASS`=0, reads return the pre-edge contents.
  - Address 0 reads 0 when `ZERO_REG`=1.
- `clr_i`=1 at an edge in RUN: go to INIT with `cnt`=0 and `ready_o`=0. User writes presented on that same edge are dropped.
- `clr_i`=1 during INIT restarts the sweep at `cnt`=0.
- Reset dominates `clr_i`. Reset in mid-INIT or mid-RUN restarts INIT at `cnt`=0.
- Width rule: data is stored and returned unmodified, with no sign or zero extension. `SP_INIT` is truncated to DATA_W.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: data is visible on reads from the cycle after the write edge, or in the same cycle via bypass.
- Init duration: `ready_o` rises on exactly the DEPTH-th rising edge with `rst_i`=1 after reset. That is 32 edges for the defaults.
- After `clr_i`, `ready_o` is low for exactly DEPTH cycles, counting from the edge after the one that sampled `clr_i`.
- No combinational path from `clr_i` or `rst_i` to the data outputs, except through the `ready_o` register.

## Structure
- Package `reg_file_pkg` holds:
  - the state enum `rf_state_t` (INIT, RUN);
  - the function `rf_init_val(idx, sp_idx, sp_init)`.
- Sub-module `reg_file_init_seq` holds the FSM and counter. Its outputs are `init_we`, `init_addr`, `init_data` and `ready`.
- The top level holds the array, the write-port merge (init dominates, then B over A) and the read/bypass muxes.

## Test plan
- Release reset, read every address each cycle:
  - `ready_o` rises on the 32nd edge;
  - reads return 0 before that;
  - afterwards reg 29 = 128 and all others 0.
- RUN, A writes reg 5 = 0xDEADBEEF and B writes reg 5 = 0x12345678 on the same edge -> reg 5 = 0x12345678 from the next cycle.
- `BYPASS`=1, A writes reg 7 = 0xA5A5A5A5 with `RSaddr_i`=7 in the same cycle -> `RSdata_o`=0xA5A5A5A5 before the edge. With `BYPASS`=0 it returns the old value.
- Write reg 0 = 0xFFFFFFFF, then read `RTaddr_i`=0 -> 0. Repeat with `ZERO_REG`=0 -> 0xFFFFFFFF.
- Load regs with nonzero data, pulse `clr_i` for one cycle:
  - `ready_o` drops the next cycle;
  - writes during INIT are ignored;
  - after 32 cycles all regs = 0 except reg 29 = 128.
- Assert `rst_i`=0 at `cnt`=10 during INIT -> sweep restarts and `ready_o` rises 32 edges after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file and its init sequencer.
package reg_file_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } rf_state_t;

   // Value the init sweep loads into register idx; callers truncate to their data width.
   function automatic logic [63:0] rf_init_val(input int idx, input int sp_idx,
                                               input logic [63:0] sp_init);
      logic [63:0] v;
      if (idx == sp_idx) begin
         v = sp_init;
      end else begin
         v = 64'd0;
      end
      return v;
   endfunction

endpackage

// File: rtl/reg_file_init_seq.sv
// Init sweep sequencer: walks every register once after reset or clear, then holds RUN.
module reg_file_init_seq
   import reg_file_pkg::*;
#(
   parameter int          ADDR_W  = 5,
   parameter int          DATA_W  = 32,
   parameter int          SP_IDX  = 29,
   parameter logic [63:0] SP_INIT = 64'd128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   output logic              init_we_o,
   output logic [ADDR_W-1:0] init_addr_o,
   output logic [DATA_W-1:0] init_data_o,
   output logic              ready_o
);

   localparam int              DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

   rf_state_t       state_q;
   logic [ADDR_W:0] cnt_q;
   logic            ready_q;

   // State, sweep counter and ready flag; clear restarts the sweep from either state.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (clr_i) begin
                  cnt_q <= '0;
               end else if (cnt_q == LAST_CNT) begin
                  state_q <= ST_RUN;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_RUN: begin
               if (clr_i) begin
                  state_q <= ST_INIT;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_INIT;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // The reset edge itself must not touch the array.
   assign init_we_o   = (state_q == ST_INIT) && rst_i;
   assign init_addr_o = cnt_q[ADDR_W-1:0];
   assign init_data_o = DATA_W'(rf_init_val(int'(cnt_q), SP_IDX, SP_INIT));
   assign ready_o     = ready_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with optional zero register, write bypass and
// a sequential init sweep gating both reads and user writes.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          ADDR_W   = 5,
   parameter int          ZERO_REG = 1,
   parameter int          BYPASS   = 1,
   parameter int          SP_IDX   = 29,
   parameter logic [63:0] SP_INIT  = 64'd128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   output logic              ready_o,
   input  logic [ADDR_W-1:0] RSaddr_i,
   input  logic [ADDR_W-1:0] RTaddr_i,
   output logic [DATA_W-1:0] RSdata_o,
   output logic [DATA_W-1:0] RTdata_o,
   input  logic [ADDR_W-1:0] WAaddr_i,
   input  logic [ADDR_W-1:0] WBaddr_i,
   input  logic [DATA_W-1:0] WAdata_i,
   input  logic [DATA_W-1:0] WBdata_i,
   input  logic              WAen_i,
   input  logic              WBen_i
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic [DATA_W-1:0] init_data;
   logic              ready;
   logic              user_ok;
   logic              wa_ok;
   logic              wb_ok;

   reg_file_init_seq #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .SP_IDX  (SP_IDX),
      .SP_INIT (SP_INIT)
   ) u_init_seq (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (clr_i),
      .init_we_o   (init_we),
      .init_addr_o (init_addr),
      .init_data_o (init_data),
      .ready_o     (ready)
   );

   // User writes only land in RUN and are dropped on reset or clear edges.
   assign user_ok = ready && rst_i && !clr_i;
   assign wa_ok   = user_ok && WAen_i && !((ZERO_REG != 0) && (WAaddr_i == '0));
   assign wb_ok   = user_ok && WBen_i && !((ZERO_REG != 0) && (WBaddr_i == '0));

   // Array update; later assignments win, so init dominates and B overrides A.
   always_ff @(posedge clk_i) begin
      if (wa_ok) begin
         mem_q[WAaddr_i] <= WAdata_i;
      end
      if (wb_ok) begin
         mem_q[WBaddr_i] <= WBdata_i;
      end
      if (init_we) begin
         mem_q[init_addr] <= init_data;
      end
   end

   function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] arr_v);
      logic [DATA_W-1:0] v;
      if (!ready) begin
         v = '0;
      end else if ((ZERO_REG != 0) && (a == '0)) begin
         v = '0;
      end else if ((BYPASS != 0) && WBen_i && (WBaddr_i == a)) begin
         v = WBdata_i;
      end else if ((BYPASS != 0) && WAen_i && (WAaddr_i == a)) begin
         v = WAdata_i;
      end else begin
         v = arr_v;
      end
      return v;
   endfunction

   // Combinational read ports with bypass and zero-register masking.
   always_comb begin
      RSdata_o = rd_sel(RSaddr_i, mem_q[RSaddr_i]);
      RTdata_o = rd_sel(RTaddr_i, mem_q[RTaddr_i]);
   end

   assign ready_o = ready;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default instance and a no-bypass/no-zero-reg instance
// checked every cycle against a spec-level model, plus hand-computed literal checks.
module tb_reg_file_mp;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic [4:0]  rs_addr, rt_addr, wa_addr, wb_addr;
   logic [31:0] wa_data, wb_data;
   logic        wa_en, wb_en;

   logic        rdy_d, rdy_a;
   logic [31:0] rs_d, rt_d, rs_a, rt_a;

   int vec  = 0;
   int fail = 0;
   bit chk_en = 1'b0;

   reg_file_mp dut (
      .clk_i (clk), .rst_i (rst_n), .clr_i (clr), .ready_o (rdy_d),
      .RSaddr_i (rs_addr), .RTaddr_i (rt_addr), .RSdata_o (rs_d), .RTdata_o (rt_d),
      .WAaddr_i (wa_addr), .WBaddr_i (wb_addr), .WAdata_i (wa_data), .WBdata_i (wb_data),
      .WAen_i (wa_en), .WBen_i (wb_en)
   );

   reg_file_mp #(.ZERO_REG(0), .BYPASS(0)) dut_alt (
      .clk_i (clk), .rst_i (rst_n), .clr_i (clr), .ready_o (rdy_a),
      .RSaddr_i (rs_addr), .RTaddr_i (rt_addr), .RSdata_o (rs_a), .RTdata_o (rt_a),
      .WAaddr_i (wa_addr), .WBaddr_i (wb_addr), .WAdata_i (wa_data), .WBdata_i (wb_data),
      .WAen_i (wa_en), .WBen_i (wb_en)
   );

   always #5 clk = ~clk;

   // Model: ready flag, edges spent in the current sweep, and visible contents per instance.
   bit          m_rdy = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_mem_d [DEPTH];
   logic [31:0] m_mem_a [DEPTH];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_rdy <= 1'b0;
         m_cnt <= 0;
      end else if (!m_rdy) begin
         if (clr) begin
            m_cnt <= 0;
         end else if (m_cnt == DEPTH - 1) begin
            m_rdy <= 1'b1;
            m_cnt <= 0;
            for (int i = 0; i < DEPTH; i++) begin
               m_mem_d[i] <= (i == 29) ? 32'd128 : 32'd0;
               m_mem_a[i] <= (i == 29) ? 32'd128 : 32'd0;
            end
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end else if (clr) begin
         m_rdy <= 1'b0;
         m_cnt <= 0;
      end else begin
         if (wa_en && wa_addr != 5'd0) m_mem_d[wa_addr] <= wa_data;
         if (wb_en && wb_addr != 5'd0) m_mem_d[wb_addr] <= wb_data;
         if (wa_en) m_mem_a[wa_addr] <= wa_data;
         if (wb_en) m_mem_a[wb_addr] <= wb_data;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit zr, input bit bp,
                                          input logic [31:0] stored);
      if (!m_rdy) return 32'd0;
      if (zr && a == 5'd0) return 32'd0;
      if (bp && wb_en && wb_addr == a) return wb_data;
      if (bp && wa_en && wa_addr == a) return wa_data;
      return stored;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready_dut", {31'd0, rdy_d}, {31'd0, m_rdy});
         chk("ready_alt", {31'd0, rdy_a}, {31'd0, m_rdy});
         chk("rs_dut", rs_d, exp_rd(rs_addr, 1'b1, 1'b1, m_mem_d[rs_addr]));
         chk("rt_dut", rt_d, exp_rd(rt_addr, 1'b1, 1'b1, m_mem_d[rt_addr]));
         chk("rs_alt", rs_a, exp_rd(rs_addr, 1'b0, 1'b0, m_mem_a[rs_addr]));
         chk("rt_alt", rt_a, exp_rd(rt_addr, 1'b0, 1'b0, m_mem_a[rt_addr]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wa_en = 1'b0;
      wb_en = 1'b0;
      clr   = 1'b0;
   endtask

   // Sweep reads and throw writes at the file until ready rises; returns edges taken.
   task automatic wait_ready(output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         rs_addr = 5'(k);
         rt_addr = 5'(31 - (k % 32));
         wa_en   = 1'b1;
         wa_addr = 5'(k);
         wa_data = 32'hC0DE_0000 + 32'(k);
         wb_en   = 1'b1;
         wb_addr = 5'(k + 3);
         wb_data = 32'hBEEF_0000 + 32'(k);
         cyc();
         n++;
         if (rdy_d) break;
      end
      idle();
   endtask

   int n;

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      rs_addr = 5'd0; rt_addr = 5'd0; wa_addr = 5'd0; wb_addr = 5'd0;
      wa_data = 32'd0; wb_data = 32'd0; wa_en = 1'b0; wb_en = 1'b0;
      cyc();
      cyc();
      chk_en = 1'b1;
      chk("reset_ready", {31'd0, rdy_d}, 32'd0);

      // Initial sweep
      rst_n = 1'b1;
      wait_ready(n);
      chk("init_edges", n, 32'd32);
      for (int i = 0; i < DEPTH; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(i);
         #1;
         if (i == 29) chk("init_sp", rs_d, 32'd128);
         if (i == 30) chk("init_r30", rt_a, 32'd0);
         cyc();
      end

      // Same-address dual write: B wins
      wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
      rs_addr = 5'd5;
      cyc();
      idle();
      #1;
      chk("dual_wr_dut", rs_d, 32'h1234_5678);
      chk("dual_wr_alt", rs_a, 32'h1234_5678);

      // Bypass versus pre-edge contents
      wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hA5A5_A5A5;
      rs_addr = 5'd7;
      #1;
      chk("bypass_dut", rs_d, 32'hA5A5_A5A5);
      chk("nobypass_alt", rs_a, 32'd0);
      cyc();
      idle();

      // Zero register
      wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
      rt_addr = 5'd9;
      cyc();
      idle();
      rt_addr = 5'd0;
      #1;
      chk("zero_reg_dut", rt_d, 32'd0);
      chk("zero_reg_alt", rt_a, 32'hFFFF_FFFF);
      cyc();

      // Fill with nonzero data, then clear with writes presented on the clear edge
      for (int i = 0; i < 16; i++) begin
         wa_en = 1'b1; wa_addr = 5'(2 * i);     wa_data = 32'h1000_0001 + 32'(i);
         wb_en = 1'b1; wb_addr = 5'(2 * i + 1); wb_data = 32'h2000_0001 + 32'(i);
         rs_addr = 5'(2 * i); rt_addr = 5'(2 * i + 1);
         cyc();
      end
      idle();
      rs_addr = 5'd3;
      #1;
      chk("filled_r3", rs_d, 32'h2000_0002);
      clr = 1'b1;
      wa_en = 1'b1; wa_addr = 5'd3;  wa_data = 32'h0000_0055;
      wb_en = 1'b1; wb_addr = 5'd29; wb_data = 32'h0000_0077;
      cyc();
      idle();
      chk("clr_ready_drop", {31'd0, rdy_d}, 32'd0);
      wait_ready(n);
      chk("clr_edges", n, 32'd32);
      rs_addr = 5'd3; rt_addr = 5'd29;
      #1;
      chk("clr_r3", rs_d, 32'd0);
      chk("clr_sp", rt_a, 32'd128);
      cyc();

      // Patterned traffic with address collisions, including address 0
      for (int i = 0; i < 40; i++) begin
         wa_en = i[0]; wa_addr = 5'((i * 7) % 32);  wa_data = 32'h3000_0000 + 32'(i * 17);
         wb_en = i[1]; wb_addr = 5'((i * 11) % 32); wb_data = 32'h4000_0000 + 32'(i * 29);
         rs_addr = 5'((i * 3) % 32);
         rt_addr = 5'((i * 7) % 32);
         cyc();
      end
      idle();

      // Reset in the middle of a sweep restarts it
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      repeat (10) cyc();
      rst_n = 1'b0;
      cyc();
      chk("midrst_ready", {31'd0, rdy_d}, 32'd0);
      rst_n = 1'b1;
      wait_ready(n);
      chk("midrst_edges", n, 32'd32);
      for (int i = 0; i < DEPTH; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(31 - i);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
